ila_capture_ctrl: RTL and testbench

Capture sequencer for the integrated logic analyzer. It samples two 10-bit probe buses, such as the display controller's horizontal and vertical counters, into an external DEPTH-entry circular sample RAM. It holds a programmable pre-trigger window, detects a comparator trigger, completes the post-trigger window, then sequences a stallable, wrap-around readout of the buffer in chronological order.

---
 rtl/ila_capture_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ila_capture_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: ILA capture sequencer (pre/post-trigger window into a circular RAM, then chronological readout).
// Define ILA_EDGE_TRIG_EN to make the comparator fire on a rising match instead of a level match.
module ila_capture_ctrl #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int PRE_TRIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [9:0]        probe_a,
    input  logic [9:0]        probe_b,
    input  logic              trig_a_en,
    input  logic              trig_b_en,
    input  logic [9:0]        trig_a_val,
    input  logic [9:0]        trig_b_val,
    input  logic              arm,
    input  logic              rd_start,
    input  logic              rd_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [19:0]       wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic [2:0]        state_dbg
);
    // Handshake: a sample is any cen=1 cycle while capturing; a read is any rd_stall=0 cycle in READ.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4,
        S_READ  = 3'd5
    } state_t;

    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_N > 0) ? POST_N - 1 : 0);
    localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

    state_t            state, state_next;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, cnt;
    logic              sample, match, trigger, do_arm, do_read, latch_trig, load_rd;

    assign match = (~trig_a_en | (probe_a == trig_a_val)) & (~trig_b_en | (probe_b == trig_b_val));

`ifdef ILA_EDGE_TRIG_EN
    logic match_prev;

    // With no comparator enabled there is no edge to see, so fall back to level.
    assign trigger = match & (~(trig_a_en | trig_b_en) | ~match_prev);

    always_ff @(posedge clk) begin
        if (rst)         match_prev <= 1'b0;
        else if (do_arm) match_prev <= 1'b0;
        else if (sample) match_prev <= match;
    end
`else
    assign trigger = match;
`endif

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        do_arm     = 1'b0;
        do_read    = 1'b0;
        latch_trig = 1'b0;
        load_rd    = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    do_arm     = 1'b1;
                    state_next = (PRE_TRIG == 0) ? S_ARMED : S_FILL;
                end
            end
            S_FILL: begin
                sample = cen;
                if (cen && cnt == PRE_LAST) state_next = S_ARMED;
            end
            S_ARMED: begin
                sample = cen;
                if (cen && trigger) begin
                    latch_trig = 1'b1;
                    state_next = (POST_N == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                sample = cen;
                if (cen && cnt == POST_LAST) state_next = S_DONE;
            end
            S_DONE: begin
                if (arm) begin
                    do_arm     = 1'b1;
                    state_next = (PRE_TRIG == 0) ? S_ARMED : S_FILL;
                end else if (rd_start) begin
                    load_rd    = 1'b1;
                    state_next = S_READ;
                end
            end
            S_READ: begin
                do_read = ~rd_stall;
                if (!rd_stall && cnt == RD_LAST) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // cnt is a per-state sample/read counter, cleared whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            state <= state_next;

            if (state_next != state)    cnt <= '0;
            else if (sample || do_read) cnt <= cnt + ADDR_W'(1);

            if (do_arm)      wr_ptr <= '0;
            else if (sample) wr_ptr <= wr_ptr + ADDR_W'(1);

            wr_en <= sample;
            if (sample) begin
                wr_addr <= wr_ptr;
                wr_data <= {probe_b, probe_a};
            end

            if (latch_trig) begin
                trig_addr  <= wr_ptr;
                start_addr <= wr_ptr - PRE_OFS;
            end

            if (load_rd)      rd_ptr <= start_addr;
            else if (do_read) rd_ptr <= rd_ptr + ADDR_W'(1);

            rd_en   <= do_read;
            rd_last <= do_read && (cnt == RD_LAST);
            if (do_read) rd_addr <= rd_ptr;

            busy <= (state_next == S_FILL) || (state_next == S_ARMED) || (state_next == S_POST);
            done <= (state_next == S_DONE);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb_ila_capture_ctrl: scoreboard bench for ila_capture_ctrl, checked against a sample-count reference model.
module tb_ila_capture_ctrl;
  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int PRE_TRIG = 4;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam int WQ_W = ADDR_W + 20;
  localparam int RQ_W = ADDR_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic cen, trig_a_en, trig_b_en, arm, rd_start, rd_stall;
  logic [9:0] probe_a, probe_b, trig_a_val, trig_b_val;
  logic wr_en, rd_en, rd_last, busy, done;
  logic [ADDR_W-1:0] wr_addr, rd_addr, trig_addr, start_addr;
  logic [19:0] wr_data;
  logic [2:0] state_dbg;

  ila_capture_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG)) dut (
    .clk(clk), .rst(rst), .cen(cen), .probe_a(probe_a), .probe_b(probe_b),
    .trig_a_en(trig_a_en), .trig_b_en(trig_b_en), .trig_a_val(trig_a_val), .trig_b_val(trig_b_val),
    .arm(arm), .rd_start(rd_start), .rd_stall(rd_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_last(rd_last),
    .busy(busy), .done(done), .trig_addr(trig_addr), .start_addr(start_addr),
    .state_dbg(state_dbg)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Capture is described by sample index: index < PRE_TRIG is pre-fill, the first later match is
  // the trigger, and the capture ends POST_N samples after it. Address = index mod DEPTH.
  logic [WQ_W-1:0] exp_wq[$];
  logic [RQ_W-1:0] exp_rq[$];
  bit m_cap = 0, m_done = 0, m_read = 0, m_mp = 0, m_match, m_hit;
  int n_samp = 0, trig_idx = -1, rd_n = 0;
  logic [ADDR_W-1:0] m_trig = '0, m_start = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cap = 0; m_done = 0; m_read = 0; m_mp = 0;
      n_samp = 0; trig_idx = -1; rd_n = 0;
      m_trig = '0; m_start = '0;
    end else if (m_cap) begin
      if (cen) begin
        m_match = (!trig_a_en || probe_a == trig_a_val) && (!trig_b_en || probe_b == trig_b_val);
`ifdef ILA_EDGE_TRIG_EN
        m_hit = m_match && (!(trig_a_en || trig_b_en) || !m_mp);
`else
        m_hit = m_match;
`endif
        exp_wq.push_back({ADDR_W'(n_samp % DEPTH), probe_b, probe_a});
        if (n_samp >= PRE_TRIG && trig_idx < 0 && m_hit) begin
          trig_idx = n_samp;
          m_trig = ADDR_W'(n_samp % DEPTH);
          m_start = ADDR_W'((n_samp % DEPTH + DEPTH - PRE_TRIG) % DEPTH);
        end
        m_mp = m_match;
        n_samp++;
        if (trig_idx >= 0 && n_samp - trig_idx - 1 == POST_N) begin
          m_cap = 0;
          m_done = 1;
        end
      end
    end else if (m_read) begin
      if (!rd_stall) begin
        exp_rq.push_back({ADDR_W'((m_start + rd_n) % DEPTH), rd_n == DEPTH - 1});
        rd_n++;
        if (rd_n == DEPTH) begin
          m_read = 0;
          m_done = 1;
        end
      end
    end else if (arm) begin
      m_cap = 1; m_done = 0; n_samp = 0; trig_idx = -1; m_mp = 0;
    end else if (m_done && rd_start) begin
      m_read = 1; m_done = 0; rd_n = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int wr_cnt = 0, rd_cnt = 0;
  logic [9:0] ram_a[DEPTH];
  logic [WQ_W-1:0] we;
  logic [RQ_W-1:0] re;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt++;
      ram_a[wr_addr] = wr_data[9:0];
      if (exp_wq.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr_unexpected: got write addr=%0d data=0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        we = exp_wq.pop_front();
        check("wr_addr", wr_addr, we[WQ_W-1:20]);
        check("wr_data", wr_data, we[19:0]);
      end
    end
    if (rd_en === 1'b1) begin
      rd_cnt++;
      if (exp_rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got read addr=%0d, expected no read", rd_addr);
      end else begin
        re = exp_rq.pop_front();
        check("rd_addr", rd_addr, re[RQ_W-1:1]);
        check("rd_last", rd_last, re[0]);
      end
    end else begin
      check("rd_last_idle", rd_last, 0);
    end
    check("busy", busy, m_cap);
    check("done", done, m_done);
    check("trig_addr", trig_addr, m_trig);
    check("start_addr", start_addr, m_start);
  end

  // ---------------- driver tasks ----------------
  int k = 0;
  int pb_max = 1023;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input logic [9:0] pa);
    cen = c;
    probe_a = pa;
    probe_b = 10'($urandom_range(0, pb_max));
    tick();
  endtask

  task automatic drive_cnt(input bit c);
    drive(c, 10'(k));
    if (c) k++;
  endtask

  task automatic pulse_arm();
    cen = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    k = 0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic readout(input bit directed);
    int cyc = 0;
    bit stalled = 0;
    rd_cnt = 0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (m_read && cyc < 200) begin
      if (directed && !stalled && rd_en === 1'b1 && rd_addr == 4'd9) begin
        stalled = 1;
        rd_stall = 1'b1;
        repeat (3) begin
          tick();
          check("stall_rd_addr", rd_addr, 9);
          check("stall_rd_en", rd_en, 0);
        end
        rd_stall = 1'b0;
      end else if (!directed) begin
        rd_stall = ($urandom_range(0, 3) == 0);
      end
      tick();
      cyc++;
    end
    rd_stall = 1'b0;
    check("readout_timeout", m_read, 0);
    if (directed) check("readout_stall_seen", stalled, 1);
    tick(); tick();
    check("readout_count", rd_cnt, DEPTH);
    check("readout_done", done, 1);
    check("readout_rq_drain", exp_rq.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int wc0;

  initial begin
    rst = 1'b1; cen = 0; arm = 0; rd_start = 0; rd_stall = 0;
    trig_a_en = 0; trig_b_en = 0; trig_a_val = 0; trig_b_val = 0;
    probe_a = 0; probe_b = 0;

    // Reset held for 5 cycles under random inputs, arm included.
    repeat (5) begin
      cen = 1'($urandom_range(0, 1)); arm = 1'($urandom_range(0, 1));
      rd_start = 1'($urandom_range(0, 1)); rd_stall = 1'($urandom_range(0, 1));
      probe_a = 10'($urandom); probe_b = 10'($urandom);
      trig_a_en = 1'($urandom_range(0, 1)); trig_a_val = 10'($urandom);
      tick();
    end
    rst = 0; cen = 0; arm = 0; rd_start = 0; rd_stall = 0;
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_state", state_dbg, 0);
    repeat (3) drive(1, 10'd0);
    check("rst_arm_ignored_busy", busy, 0);
    check("rst_no_writes", wr_cnt, 0);

    // Basic capture: trigger on probe_a == 10.
    trig_a_en = 1; trig_a_val = 10; trig_b_en = 0;
    wr_cnt = 0;
    pulse_arm();
    for (int c = 0; c < 200 && !m_done; c++) drive_cnt(1);
    tick(); tick();
    check("basic_done", done, 1);
    check("basic_trig_addr", trig_addr, 10);
    check("basic_start_addr", start_addr, 6);
    check("basic_wr_count", wr_cnt, 22);
    check("basic_ram6", ram_a[6], 6);
    check("basic_ram5", ram_a[5], 21);
    check("basic_wq_drain", exp_wq.size(), 0);

    // Readout with a 3-cycle stall once address 9 has been read.
    readout(1);

    // cen gating: alternate cen, same trigger.
    wr_cnt = 0;
    pulse_arm();
    for (int c = 0; c < 400 && !m_done; c++) drive_cnt(c % 2 == 0);
    tick(); tick();
    check("cen_done", done, 1);
    check("cen_trig_addr", trig_addr, 10);
    check("cen_wr_count", wr_cnt, 22);
    check("cen_wq_drain", exp_wq.size(), 0);

    // Match during pre-fill must be ignored.
    trig_a_val = 2;
    pulse_arm();
    repeat (200) drive_cnt(1);
    check("fill_ignore_done", done, 0);
    check("fill_ignore_busy", busy, 1);
    pulse_rst();

    // arm while ARMED is ignored; reset mid-POST stops all writes.
    trig_a_val = 10'd1023;
    pulse_arm();
    repeat (8) drive_cnt(1);
    arm = 1'b1;
    drive_cnt(1);
    arm = 1'b0;
    check("armed_arm_ignored", busy, 1);
    trig_a_val = 10'(k + 1);
    repeat (2) drive_cnt(1);
    check("abort_trig_addr", trig_addr, 10);
    repeat (3) drive_cnt(1);
    pulse_rst();
    wc0 = wr_cnt;
    repeat (10) drive_cnt(1);
    check("abort_no_writes", wr_cnt, wc0);
    check("abort_idle", busy, 0);
    check("abort_wq_drain", exp_wq.size(), 0);

    // Probe held at the compare value, then a dip and return.
    trig_a_val = 10;
    pulse_arm();
    repeat (20) drive(1, 10'd10);
`ifdef ILA_EDGE_TRIG_EN
    check("edge_hold_no_trig", done, 0);
`endif
    drive(1, 10'd11);
    drive(1, 10'd10);
`ifdef ILA_EDGE_TRIG_EN
    check("edge_trig_addr", trig_addr, 5);
`endif
    for (int c = 0; c < 40 && !m_done; c++) drive(1, 10'd3);
    check("edge_done", done, 1);
    readout(0);

    // Randomized captures and readouts.
    pb_max = 7;
    for (int r = 0; r < 8; r++) begin
      trig_a_en = 1'($urandom_range(0, 1));
      trig_b_en = 1'($urandom_range(0, 1));
      trig_a_val = 10'($urandom_range(0, 7));
      trig_b_val = 10'($urandom_range(0, 7));
      pulse_arm();
      for (int c = 0; c < 300 && !m_done; c++)
        drive($urandom_range(0, 3) != 0, 10'($urandom_range(0, 7)));
      cen = 0;
      tick(); tick();
      if (m_done) readout(0);
      else pulse_rst();
      check("rand_wq_drain", exp_wq.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
